// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one SPI pin set (clock, MOSI, three chip selects)
// between the OLED controller (0), the PSRAM master (1) and the flash master (2).
// Ownership is granted round-robin and held until the owner drops its request.
// Each release is followed by a deselect turnaround. An optional watchdog
// revokes an owner that holds the bus for too long.
//
// Handshake: a requester raises req and holds it until it sees gnt. It then
// keeps req high for the whole transaction and drops it to release the bus.
// gnt is registered and rises on the clock edge that samples the winning req.
// It falls on the edge that samples req low, or when the watchdog fires.
module spi_bus_arbiter #(
  parameter int          TURN_CYCLES = 4,
  parameter logic [15:0] MAX_HOLD    = 16'd0,
  parameter logic        CLK_IDLE    = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       oled_req,
  input  logic       psram_req,
  input  logic       flash_req,
  output logic       oled_gnt,
  output logic       psram_gnt,
  output logic       flash_gnt,
  input  logic       oled_sclk,
  input  logic       psram_sclk,
  input  logic       flash_sclk,
  input  logic       oled_mosi,
  input  logic       psram_mosi,
  input  logic       flash_mosi,
  input  logic       oled_cs_n,
  input  logic       psram_cs_n_i,
  input  logic       flash_cs_n_i,
  output logic       spi_clk,
  output logic       spi_mosi,
  output logic       lcd_cs_n,
  output logic       psram_cs_n,
  output logic       flash_cs_n,
  output logic [1:0] owner,
  output logic       timeout,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_t;

  localparam logic [15:0] TURN_LD  = 16'(TURN_CYCLES);
  localparam logic        HAS_TURN = (TURN_CYCLES > 0);
  localparam logic [1:0]  NO_OWNER = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [1:0]  last_owner_q;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  cs_q, cs_d;
  logic        spi_clk_q, spi_clk_d;
  logic        spi_mosi_q, spi_mosi_d;
  logic        timeout_q, timeout_d;
  logic [15:0] hold_cnt_q;
  logic [15:0] turn_cnt_q;
  logic [2:0]  blocked_q;

  logic [2:0]  req_v, sclk_v, mosi_v, csn_v;
  logic [2:0]  eligible, own_oh, win_oh;
  logic [2:0]  pick;
  logic        found;
  logic [1:0]  win;
  logic        in_own, owner_req, release_own, wd_fire, end_own;

  // Round-robin search starting one past the last owner; result is {found, index}
  function automatic logic [2:0] rr_pick(input logic [2:0] elig, input logic [1:0] last);
    logic [1:0] cand;
    rr_pick = 3'b000;
    cand = (last >= 2'd2) ? 2'd0 : last + 2'd1;
    for (int k = 0; k < 3; k++) begin
      if (!rr_pick[2] && elig[cand]) rr_pick = {1'b1, cand};
      cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
    end
  endfunction

  assign req_v  = {flash_req, psram_req, oled_req};
  assign sclk_v = {flash_sclk, psram_sclk, oled_sclk};
  assign mosi_v = {flash_mosi, psram_mosi, oled_mosi};
  assign csn_v  = {flash_cs_n_i, psram_cs_n_i, oled_cs_n};

  // A revoked requester stays out of arbitration until its req is seen low
  assign eligible = req_v & ~blocked_q;
  assign pick     = rr_pick(eligible, last_owner_q);
  assign found    = pick[2];
  assign win      = pick[1:0];
  assign win_oh   = 3'b001 << win;

  // owner_q is 3 outside OWN, which shifts the one-hot to all zeros
  assign own_oh      = 3'b001 << owner_q;
  assign in_own      = (state_q == S_OWN);
  assign owner_req   = |(req_v & own_oh);
  assign release_own = in_own && !owner_req;
  assign wd_fire     = in_own && owner_req && (MAX_HOLD != 16'd0) &&
                       (hold_cnt_q + 16'd1 == MAX_HOLD);
  assign end_own     = release_own || wd_fire;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (found) state_d = S_OWN;
      S_OWN:  if (end_own) state_d = HAS_TURN ? S_TURN : S_IDLE;
      S_TURN: if (turn_cnt_q <= 16'd1) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered grant, owner and pin outputs
  always_comb begin
    gnt_d      = 3'b000;
    owner_d    = NO_OWNER;
    cs_d       = 3'b111;
    spi_clk_d  = CLK_IDLE;
    spi_mosi_d = 1'b0;
    timeout_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d   = win_oh;
          owner_d = win;
        end
      end
      S_OWN: begin
        if (!end_own) begin
          gnt_d      = own_oh;
          owner_d    = owner_q;
          spi_clk_d  = |(sclk_v & own_oh);
          spi_mosi_d = |(mosi_v & own_oh);
          cs_d       = ~own_oh | ({3{|(csn_v & own_oh)}} & own_oh);
        end
        timeout_d = wd_fire;
      end
      default: ;
    endcase
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_q      <= 3'b000;
      owner_q    <= NO_OWNER;
      cs_q       <= 3'b111;
      spi_clk_q  <= CLK_IDLE;
      spi_mosi_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      cs_q       <= cs_d;
      spi_clk_q  <= spi_clk_d;
      spi_mosi_q <= spi_mosi_d;
      timeout_q  <= timeout_d;
    end
  end

  // Round-robin pointer, hold and turnaround counters, watchdog block flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_owner_q <= 2'd2;
      hold_cnt_q   <= 16'd0;
      turn_cnt_q   <= 16'd0;
      blocked_q    <= 3'b000;
    end else begin
      blocked_q <= (blocked_q & req_v) | (wd_fire ? own_oh : 3'b000);
      case (state_q)
        S_IDLE: if (found) hold_cnt_q <= 16'd0;
        S_OWN: begin
          if (end_own) begin
            last_owner_q <= owner_q;
            turn_cnt_q   <= TURN_LD;
          end else begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
          end
        end
        S_TURN: turn_cnt_q <= turn_cnt_q - 16'd1;
        default: ;
      endcase
    end
  end

  assign oled_gnt   = gnt_q[0];
  assign psram_gnt  = gnt_q[1];
  assign flash_gnt  = gnt_q[2];
  assign lcd_cs_n   = cs_q[0];
  assign psram_cs_n = cs_q[1];
  assign flash_cs_n = cs_q[2];
  assign spi_clk    = spi_clk_q;
  assign spi_mosi   = spi_mosi_q;
  assign owner      = owner_q;
  assign timeout    = timeout_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter. Instance a uses TURN_CYCLES=4 and MAX_HOLD=100.
// Instance b uses TURN_CYCLES=0 with the watchdog off.
module tb_spi_bus_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- instance a ----------------
  logic oled_req, psram_req, flash_req;
  logic oled_sclk, psram_sclk, flash_sclk;
  logic oled_mosi, psram_mosi, flash_mosi;
  logic oled_cs_n, psram_cs_n_i, flash_cs_n_i;
  logic oled_gnt, psram_gnt, flash_gnt;
  logic spi_clk, spi_mosi, lcd_cs_n, psram_cs_n, flash_cs_n, timeout;
  logic [1:0] owner, fsm_state;

  spi_bus_arbiter #(.TURN_CYCLES(4), .MAX_HOLD(16'd100), .CLK_IDLE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .oled_req(oled_req), .psram_req(psram_req), .flash_req(flash_req),
    .oled_gnt(oled_gnt), .psram_gnt(psram_gnt), .flash_gnt(flash_gnt),
    .oled_sclk(oled_sclk), .psram_sclk(psram_sclk), .flash_sclk(flash_sclk),
    .oled_mosi(oled_mosi), .psram_mosi(psram_mosi), .flash_mosi(flash_mosi),
    .oled_cs_n(oled_cs_n), .psram_cs_n_i(psram_cs_n_i), .flash_cs_n_i(flash_cs_n_i),
    .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .lcd_cs_n(lcd_cs_n), .psram_cs_n(psram_cs_n), .flash_cs_n(flash_cs_n),
    .owner(owner), .timeout(timeout), .fsm_state(fsm_state)
  );

  // ---------------- instance b ----------------
  logic b_oled_req, b_psram_req, b_flash_req;
  logic b_oled_gnt, b_psram_gnt, b_flash_gnt;
  logic b_spi_clk, b_spi_mosi, b_lcd_cs_n, b_psram_cs_n, b_flash_cs_n, b_timeout;
  logic [1:0] b_owner, b_fsm_state;

  spi_bus_arbiter #(.TURN_CYCLES(0), .MAX_HOLD(16'd0), .CLK_IDLE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .oled_req(b_oled_req), .psram_req(b_psram_req), .flash_req(b_flash_req),
    .oled_gnt(b_oled_gnt), .psram_gnt(b_psram_gnt), .flash_gnt(b_flash_gnt),
    .oled_sclk(1'b0), .psram_sclk(1'b0), .flash_sclk(1'b0),
    .oled_mosi(1'b0), .psram_mosi(1'b0), .flash_mosi(1'b0),
    .oled_cs_n(1'b1), .psram_cs_n_i(1'b1), .flash_cs_n_i(1'b1),
    .spi_clk(b_spi_clk), .spi_mosi(b_spi_mosi),
    .lcd_cs_n(b_lcd_cs_n), .psram_cs_n(b_psram_cs_n), .flash_cs_n(b_flash_cs_n),
    .owner(b_owner), .timeout(b_timeout), .fsm_state(b_fsm_state)
  );

  wire [2:0]  a_gnt  = {flash_gnt, psram_gnt, oled_gnt};
  wire [2:0]  b_gnt  = {b_flash_gnt, b_psram_gnt, b_oled_gnt};
  wire [10:0] a_outs = {a_gnt, lcd_cs_n, psram_cs_n, flash_cs_n, spi_clk, spi_mosi, owner, timeout};
  wire [10:0] b_outs = {b_gnt, b_lcd_cs_n, b_psram_cs_n, b_flash_cs_n, b_spi_clk, b_spi_mosi, b_owner, b_timeout};
  wire [3:0]  a_idle_pins = {lcd_cs_n, psram_cs_n, flash_cs_n, spi_clk};
  localparam logic [10:0] IDLE_OUTS = {3'b000, 3'b111, 1'b0, 1'b0, 2'b11, 1'b0};

  // ---------------- scoreboard ----------------
  logic [1:0] exp_q[$];
  logic [4:0] exp_pin_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    oled_req = 0; psram_req = 0; flash_req = 0;
    oled_sclk = 0; psram_sclk = 0; flash_sclk = 0;
    oled_mosi = 0; psram_mosi = 0; flash_mosi = 0;
    oled_cs_n = 1; psram_cs_n_i = 1; flash_cs_n_i = 1;
    b_oled_req = 0; b_psram_req = 0; b_flash_req = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    rst_n = 0;
    tick();
    n_cmp++;
    if (a_outs !== IDLE_OUTS) begin
      n_err++; $display("FAIL reset_a_outs: got %b expected %b", a_outs, IDLE_OUTS);
    end
    n_cmp++;
    if (b_outs !== IDLE_OUTS) begin
      n_err++; $display("FAIL reset_b_outs: got %b expected %b", b_outs, IDLE_OUTS);
    end
    rst_n = 1;
    tick(); tick();
    n_cmp++;
    if (a_outs !== IDLE_OUTS) begin
      n_err++; $display("FAIL idle_no_req: got %b expected %b", a_outs, IDLE_OUTS);
    end
  endtask

  task automatic test_psram_pins();
    logic [1:0] e;
    logic [4:0] ep;
    logic s, m;
    drive_idle();
    apply_reset();
    for (int i = 0; i < 8; i++) tick();
    psram_req = 1;
    exp_q.push_back(2'd1);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (owner !== e || a_gnt !== (3'b001 << e)) begin
      n_err++; $display("FAIL psram_grant: got owner %0d gnt %b expected owner %0d", owner, a_gnt, e);
    end
    tick();
    psram_cs_n_i = 0;
    n_cmp++;
    if ({lcd_cs_n, psram_cs_n, flash_cs_n} !== 3'b111) begin
      n_err++; $display("FAIL psram_cs_first: got %b expected 111", {lcd_cs_n, psram_cs_n, flash_cs_n});
    end
    tick();
    n_cmp++;
    if ({lcd_cs_n, psram_cs_n, flash_cs_n} !== 3'b101) begin
      n_err++; $display("FAIL psram_cs_follow: got %b expected 101", {lcd_cs_n, psram_cs_n, flash_cs_n});
    end
    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      psram_sclk = s; psram_mosi = m;
      oled_sclk = 1'($urandom_range(0, 1)); flash_mosi = 1'($urandom_range(0, 1));
      oled_cs_n = 1'($urandom_range(0, 1)); flash_cs_n_i = 1'($urandom_range(0, 1));
      exp_pin_q.push_back({s, m, 3'b101});
      tick();
      ep = exp_pin_q.pop_front();
      n_cmp++;
      if ({spi_clk, spi_mosi, lcd_cs_n, psram_cs_n, flash_cs_n} !== ep) begin
        n_err++; $display("FAIL psram_pins[%0d]: got %b expected %b", i,
                          {spi_clk, spi_mosi, lcd_cs_n, psram_cs_n, flash_cs_n}, ep);
      end
    end
    oled_cs_n = 1; flash_cs_n_i = 1; psram_sclk = 1; psram_mosi = 1;
    psram_req = 0;
    tick();
    n_cmp++;
    if (a_outs !== IDLE_OUTS) begin
      n_err++; $display("FAIL psram_release: got %b expected %b", a_outs, IDLE_OUTS);
    end
    drive_idle();
  endtask

  task automatic test_cs_release();
    drive_idle();
    apply_reset();
    oled_req = 1;
    tick();
    n_cmp++;
    if (a_gnt !== 3'b001) begin
      n_err++; $display("FAIL oled_grant: got %b expected 001", a_gnt);
    end
    oled_cs_n = 0;
    tick(); tick();
    n_cmp++;
    if (lcd_cs_n !== 1'b0) begin
      n_err++; $display("FAIL oled_cs_low: got %b expected 0", lcd_cs_n);
    end
    oled_req = 0;
    tick();
    n_cmp++;
    if (lcd_cs_n !== 1'b1 || a_gnt !== 3'b000 || owner !== 2'd3) begin
      n_err++; $display("FAIL oled_forced_idle: got cs %b gnt %b owner %0d expected 1 000 3", lcd_cs_n, a_gnt, owner);
    end
    tick();
    n_cmp++;
    if (lcd_cs_n !== 1'b1) begin
      n_err++; $display("FAIL oled_cs_stays_high: got %b expected 1", lcd_cs_n);
    end
    drive_idle();
  endtask

  task automatic test_round_robin();
    logic [1:0] e;
    int gap;
    logic got, idle_bad, hold_bad;
    drive_idle();
    oled_req = 1; psram_req = 1; flash_req = 1;
    apply_reset();
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    gap = 0;
    idle_bad = 0;
    for (int g = 0; g < 3; g++) begin
      got = 0;
      for (int c = 0; c < 40; c++) begin
        tick();
        if (a_gnt !== 3'b000) begin
          got = 1;
          break;
        end
        gap++;
        if (a_idle_pins !== 4'b1110) idle_bad = 1;
      end
      n_cmp++;
      if (!got) begin
        n_err++; $display("FAIL rr_wait[%0d]: got no grant expected a grant within 40 cycles", g);
        return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (owner !== e || a_gnt !== (3'b001 << e)) begin
        n_err++; $display("FAIL rr_order[%0d]: got owner %0d gnt %b expected owner %0d", g, owner, a_gnt, e);
      end
      if (g > 0) begin
        n_cmp++;
        if (gap !== 5) begin
          n_err++; $display("FAIL rr_gap[%0d]: got %0d expected 5", g, gap);
        end
        n_cmp++;
        if (idle_bad !== 1'b0) begin
          n_err++; $display("FAIL rr_gap_idle[%0d]: got pins active expected idle", g);
        end
      end
      hold_bad = 0;
      for (int i = 1; i < 20; i++) begin
        tick();
        if (a_gnt !== (3'b001 << e)) hold_bad = 1;
      end
      n_cmp++;
      if (hold_bad !== 1'b0) begin
        n_err++; $display("FAIL rr_hold[%0d]: got grant lost expected held 20 cycles", g);
      end
      case (e)
        2'd0: oled_req = 0;
        2'd1: psram_req = 0;
        default: flash_req = 0;
      endcase
      tick();
      n_cmp++;
      if (a_gnt !== 3'b000) begin
        n_err++; $display("FAIL rr_release[%0d]: got %b expected 000", g, a_gnt);
      end
      gap = 1;
      idle_bad = (a_idle_pins !== 4'b1110);
    end
    drive_idle();
  endtask

  task automatic test_watchdog();
    logic [1:0] e;
    int held, regrants, pulses;
    logic got;
    drive_idle();
    apply_reset();
    flash_req = 1;
    exp_q.push_back(2'd2);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (owner !== e || flash_gnt !== 1'b1) begin
      n_err++; $display("FAIL wd_grant: got owner %0d gnt %b expected owner %0d", owner, flash_gnt, e);
    end
    held = 1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (flash_gnt !== 1'b1) break;
      held++;
    end
    n_cmp++;
    if (held !== 100) begin
      n_err++; $display("FAIL wd_hold_len: got %0d expected 100", held);
    end
    n_cmp++;
    if (timeout !== 1'b1) begin
      n_err++; $display("FAIL wd_timeout_pulse: got %b expected 1", timeout);
    end
    regrants = 0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (flash_gnt === 1'b1) regrants++;
      if (timeout === 1'b1) pulses++;
    end
    n_cmp++;
    if (regrants !== 0 || pulses !== 0) begin
      n_err++; $display("FAIL wd_blocked: got %0d grant cycles %0d extra pulses expected 0 0", regrants, pulses);
    end
    flash_req = 0;
    tick();
    flash_req = 1;
    exp_q.push_back(2'd2);
    got = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (flash_gnt === 1'b1) begin
        got = 1;
        break;
      end
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (!got || owner !== e) begin
      n_err++; $display("FAIL wd_regrant: got granted %b owner %0d expected 1 %0d", got, owner, e);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_reset_mid();
    logic [1:0] e;
    drive_idle();
    apply_reset();
    psram_req = 1;
    tick();
    psram_cs_n_i = 0;
    for (int i = 0; i < 6; i++) begin
      psram_sclk = ~psram_sclk;
      psram_mosi = 1'($urandom_range(0, 1));
      tick();
    end
    rst_n = 0;
    tick();
    n_cmp++;
    if (a_outs !== IDLE_OUTS) begin
      n_err++; $display("FAIL mid_reset_outs: got %b expected %b", a_outs, IDLE_OUTS);
    end
    rst_n = 1;
    oled_req = 1; flash_req = 1;
    exp_q.push_back(2'd0);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (owner !== e || a_gnt !== (3'b001 << e)) begin
      n_err++; $display("FAIL mid_reset_first: got owner %0d gnt %b expected owner %0d", owner, a_gnt, e);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_turn_zero();
    logic [1:0] e;
    drive_idle();
    b_oled_req = 1; b_psram_req = 1;
    apply_reset();
    exp_q.push_back(2'd0);
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (b_owner !== e || b_gnt !== 3'b001) begin
      n_err++; $display("FAIL t0_first: got owner %0d gnt %b expected owner %0d", b_owner, b_gnt, e);
    end
    for (int i = 0; i < 5; i++) tick();
    b_oled_req = 0;
    exp_q.push_back(2'd1);
    tick();
    n_cmp++;
    if (b_gnt !== 3'b000) begin
      n_err++; $display("FAIL t0_release: got %b expected 000", b_gnt);
    end
    tick();
    e = exp_q.pop_front();
    n_cmp++;
    if (b_owner !== e || b_gnt !== 3'b010) begin
      n_err++; $display("FAIL t0_next_grant: got owner %0d gnt %b expected owner %0d", b_owner, b_gnt, e);
    end
    drive_idle();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive_idle();
    rst_n = 0;
    test_reset();
    test_psram_pins();
    test_cs_release();
    test_round_robin();
    test_watchdog();
    test_reset_mid();
    test_turn_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run expected finish before 200000 ns");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/spi_bus_arbiter.md
# spi_bus_arbiter

Shares the single on-board SPI pin set (`spi_clk`, `spi_mosi_io0`, three chip selects) between three masters: OLED controller (requester 0), PSRAM master (requester 1) and flash master (requester 2). Grants are round-robin and transaction-locked: the owner keeps the bus until it drops its request. Every ownership change inserts a deselect turnaround, and an optional watchdog revokes a stuck owner. Sits between the SPI masters and the top-level pins; `spi_miso_io1` fans out directly to all masters and is not routed through this block.

## Interface

Parameters:
- `TURN_CYCLES`, default 4: cycles with all CS high and clock idle after each release (0 allowed).
- `MAX_HOLD`, default 0: maximum owner hold, in cycles; 0 disables the watchdog. 16-bit.
- `CLK_IDLE`, default 1'b0: `spi_clk` level whenever no owner drives it.

Ports:
- `clk` in 1: system clock, the 50 MHz OSC clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `oled_req`, `psram_req`, `flash_req` in 1 each: bus request. Must stay high for the whole transaction.
- `oled_gnt`, `psram_gnt`, `flash_gnt` out 1 each: bus grant, registered.
- `oled_sclk`, `psram_sclk`, `flash_sclk` in 1 each: requester SPI clock.
- `oled_mosi`, `psram_mosi`, `flash_mosi` in 1 each: requester MOSI.
- `oled_cs_n`, `psram_cs_n_i`, `flash_cs_n_i` in 1 each: requester chip select.
- `spi_clk` out 1: pin clock, registered.
- `spi_mosi` out 1: pin MOSI, registered.
- `lcd_cs_n`, `psram_cs_n`, `flash_cs_n` out 1 each: pin chip selects, registered.
- `owner` out 2: current owner, 0/1/2; 3 means none.
- `timeout` out 1: one-cycle pulse when the watchdog revokes a grant.

## Operation

- States: IDLE, OWN, TURN.
- IDLE:
  - All CS high, `spi_clk`=CLK_IDLE, `spi_mosi`=0, all gnt 0, `owner`=3.
  - Any eligible req → OWN with the winner. A requester is eligible only if its req is high and it is not blocked.
  - Winner is chosen by round-robin, starting search at `(last_owner+1) mod 3`.
- OWN:
  - Owner's gnt=1.
  - Pins register the owner's sclk/mosi. Owner's own CS pin registers its cs_n; the other two CS pins are held at 1.
  - Non-owner inputs are ignored.
- Release: owner req=0 → gnt=0, `last_owner`=owner.
  - Go to TURN if TURN_CYCLES>0, else IDLE.
  - Pins are forced to idle values immediately, regardless of the owner's cs_n.
- TURN: down-counter runs TURN_CYCLES cycles with pins idle and `owner`=3, then IDLE.
- Watchdog, active when MAX_HOLD>0:
  - Hold counter clears on entry to OWN and increments each OWN cycle.
  - When it reaches MAX_HOLD: pulse `timeout` for one cycle, then treat as a release.
  - The revoked requester is marked blocked. The block clears when its req is sampled low.
  - This stops a requester from regaining the bus with a request that never dropped.
- Reset, including mid-transaction:
  - State IDLE, `last_owner`=2, so OLED has first priority.
  - Counters 0, blocked flags 0, all outputs at idle values.
- Reset values of outputs: gnt 0/0/0, all CS 1, `spi_clk`=CLK_IDLE, `spi_mosi`=0, `owner`=3, `timeout`=0.

## Timing

- Grant latency: a req sampled high at edge E in IDLE gives gnt=1 and the new `owner` after E.
- Pin latency: pins follow the owner's inputs with one register stage.
  - The requester's drive in cycle k appears on the pins in cycle k+1.
  - Requesters must hold cs_n high in the first gnt cycle and must keep SPI timing relative to their own outputs.
- Release latency: req sampled low at edge R gives gnt=0 and forced-idle pins after R.
- Turnaround: minimum gap from gnt falling to the next gnt rising is TURN_CYCLES+1 cycles (the +1 is the arbitration cycle in IDLE).
- Simultaneous requests are served in round-robin order. With `last_owner`=2 the order is 0, 1, 2.
- A req dropping and re-rising during TURN waits for IDLE arbitration.
- A req pulse shorter than one cycle while the block is not in IDLE is not captured. Requesters hold req until gnt.

## Test plan

- Reset then `psram_req`=1 at cycle 10:
  - `psram_gnt`=1 and `owner`=1 at cycle 11.
  - `psram_cs_n_i`=0 driven at cycle 12 appears on `psram_cs_n` at cycle 13.
  - `lcd_cs_n` and `flash_cs_n` stay 1 throughout.
- All three reqs high from reset, each dropping after 20 cycles of gnt, TURN_CYCLES=4:
  - Grants in order OLED, PSRAM, flash.
  - Each gap from gnt=0 to the next gnt=1 is exactly 5 cycles.
  - All CS and `spi_clk`=CLK_IDLE during every gap.
- OLED holds cs_n=0 and drops req:
  - `lcd_cs_n` returns to 1 the cycle after release, not the cycle after OLED raises cs_n.
- MAX_HOLD=100 with flash never dropping req:
  - `timeout` pulses once at hold count 100 and `flash_gnt` falls.
  - Flash is not regranted while its req stays high.
  - After req drops for 1 cycle and re-rises, it is granted again.
- `rst_n`=0 for 1 cycle mid-PSRAM transfer (toggling sclk):
  - Next cycle all CS 1, `spi_clk`=CLK_IDLE, gnt 0, `owner`=3.
  - If all three reqs are then held high, the first grant goes to OLED.
- TURN_CYCLES=0, OLED releases while PSRAM is waiting:
  - `psram_gnt` rises exactly 1 cycle after `oled_gnt` falls.
